// File: rtl/maze_pkg.sv
// maze_pkg: constants and enums shared by the maze generator and solver.
// Direction encoding is common to both blocks.
package maze_pkg;

  localparam int SIZE  = 9;
  localparam int CELLS = (SIZE - 1) / 2;
  localparam int CW    = 3;
  localparam int DEPTH = CELLS * CELLS;
  localparam int LEN_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    DIR_DOWN,
    DIR_RIGHT,
    DIR_UP,
    DIR_LEFT
  } dir_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FIND_ENTRY,
    S_FIND_EXIT,
    S_PUSH_START,
    S_VISIT,
    S_CHECK,
    S_ADVANCE,
    S_BACKTRACK,
    S_FOUND,
    S_FAIL,
    S_DONE
  } state_e;

endpackage

// File: rtl/maze_stack.sv
// maze_stack: LIFO of packed {y,x} cell coordinates.
// Exposes top and the entry below it (the parent cell).
module maze_stack #(
  parameter int W     = 6,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic [W-1:0] below,
  output logic         empty,
  output logic         one
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp1;
  logic [PW-1:0] sp2;

  assign sp1   = sp - PW'(1);
  assign sp2   = sp - PW'(2);
  assign top   = mem[sp1[AW-1:0]];
  assign below = mem[sp2[AW-1:0]];
  assign empty = (sp == '0);
  assign one   = (sp == PW'(1));

  // Stack pointer and storage; clear empties the stack.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sp <= '0;
    end else if (push) begin
      mem[sp[AW-1:0]] <= din;
      sp <= sp + PW'(1);
    end else if (pop) begin
      sp <= sp - PW'(1);
    end
  end

endmodule

// File: rtl/maze_solver.sv
// maze_solver: depth-first search from the top opening to the bottom
// opening of a wall bitmap, producing the solution path bitmap.
module maze_solver
  import maze_pkg::*;
#(
  parameter int size = SIZE,
  parameter int N    = CW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [size-1:0][size-1:0]   maze,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [size-1:0][size-1:0]   path,
  output logic [$clog2(((size-1)/2)*((size-1)/2)+1)-1:0] path_len
);

  localparam int NC = (size - 1) / 2;
  localparam int ND = NC * NC;
  localparam int SW = $clog2(size);
  localparam int VW = $clog2(ND);
  localparam int LW = $clog2(ND + 1);
  localparam logic [N-1:0] CMAX  = N'(NC);
  localparam logic [N-1:0] CLAST = N'(NC - 1);

  state_e state;
  state_e state_nx;
  dir_e   dir;

  logic [size-1:0][size-1:0] snap;
  logic [ND-1:0]  visited;
  logic [N-1:0]   idx;
  logic [N-1:0]   entry_x;
  logic [N-1:0]   exit_x;
  logic [2*N-1:0] top;
  logic [2*N-1:0] below;
  logic [2*N-1:0] din;
  logic           push;
  logic           pop;
  logic           empty;
  logic           one;
  logic           accept;
  logic [N-1:0]   cur_y;
  logic [N-1:0]   cur_x;
  logic [N-1:0]   par_y;
  logic [N-1:0]   par_x;
  logic [N-1:0]   nb_y;
  logic [N-1:0]   nb_x;
  logic [SW-1:0]  cor_r;
  logic [SW-1:0]  cor_c;
  logic [SW-1:0]  par_r;
  logic [SW-1:0]  par_c;
  logic           nb_ok;
  logic           can_go;
  logic           at_exit;

  function automatic logic [SW-1:0] sq(input logic [N-1:0] c);
    return SW'({c, 1'b1});
  endfunction

  function automatic logic [VW-1:0] vidx(input logic [N-1:0] y,
                                         input logic [N-1:0] x);
    return VW'(int'(y) * NC + int'(x));
  endfunction

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign cur_y  = top[2*N-1:N];
  assign cur_x  = top[N-1:0];
  assign par_y  = below[2*N-1:N];
  assign par_x  = below[N-1:0];
  assign cor_r  = SW'(cur_y) + SW'(nb_y) + SW'(1);
  assign cor_c  = SW'(cur_x) + SW'(nb_x) + SW'(1);
  assign par_r  = SW'(cur_y) + SW'(par_y) + SW'(1);
  assign par_c  = SW'(cur_x) + SW'(par_x) + SW'(1);
  assign nb_ok  = (nb_y < CMAX) && (nb_x < CMAX);
  assign can_go = nb_ok && !snap[cor_r][cor_c]
                  && !visited[vidx(nb_y, nb_x)];
  assign at_exit = (cur_y == CLAST) && (cur_x == exit_x);
  assign din = (state == S_PUSH_START) ? {N'(0), entry_x}
                                       : {nb_y, nb_x};

  maze_stack #(
    .W     (2 * N),
    .DEPTH (ND)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .top   (top),
    .below (below),
    .empty (empty),
    .one   (one)
  );

  // Neighbour of the top-of-stack cell in the current direction.
  always_comb begin
    nb_y = cur_y;
    nb_x = cur_x;
    unique case (dir)
      DIR_DOWN:  nb_y = cur_y + N'(1);
      DIR_RIGHT: nb_x = cur_x + N'(1);
      DIR_UP:    nb_y = cur_y - N'(1);
      default:   nb_x = cur_x - N'(1);
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and stack control.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (state)
      S_IDLE, S_DONE:
        if (start) state_nx = S_FIND_ENTRY;
      S_FIND_ENTRY:
        if (!snap[0][sq(idx)])  state_nx = S_FIND_EXIT;
        else if (idx == CLAST)  state_nx = S_FAIL;
      S_FIND_EXIT:
        if (!snap[size-1][sq(idx)]) state_nx = S_PUSH_START;
        else if (idx == CLAST)      state_nx = S_FAIL;
      S_PUSH_START: begin
        push     = 1'b1;
        state_nx = S_VISIT;
      end
      S_VISIT:
        if (empty)        state_nx = S_FAIL;
        else if (at_exit) state_nx = S_FOUND;
        else              state_nx = S_CHECK;
      S_CHECK:
        if (can_go)               state_nx = S_ADVANCE;
        else if (dir == DIR_LEFT) state_nx = S_BACKTRACK;
      S_ADVANCE: begin
        push     = 1'b1;
        state_nx = S_VISIT;
      end
      S_BACKTRACK: begin
        pop      = 1'b1;
        state_nx = one ? S_FAIL : S_VISIT;
      end
      S_FOUND, S_FAIL:
        state_nx = S_DONE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Datapath: snapshot, scan index, visited map and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      path     <= '0;
      path_len <= '0;
      visited  <= '0;
      snap     <= '0;
      idx      <= '0;
      entry_x  <= '0;
      exit_x   <= '0;
      dir      <= DIR_DOWN;
    end else if (accept) begin
      snap     <= maze;
      busy     <= 1'b1;
      done     <= 1'b0;
      found    <= 1'b0;
      path     <= '0;
      path_len <= '0;
      visited  <= '0;
      idx      <= '0;
    end else begin
      unique case (state)
        S_FIND_ENTRY:
          if (!snap[0][sq(idx)]) begin
            entry_x <= idx;
            idx     <= '0;
          end else begin
            idx <= idx + N'(1);
          end
        S_FIND_EXIT:
          if (!snap[size-1][sq(idx)]) exit_x <= idx;
          else                        idx    <= idx + N'(1);
        S_PUSH_START: begin
          visited[vidx(N'(0), entry_x)] <= 1'b1;
          path[0][sq(entry_x)] <= 1'b1;
          path[1][sq(entry_x)] <= 1'b1;
          path_len <= LW'(1);
        end
        S_VISIT:
          dir <= DIR_DOWN;
        S_CHECK:
          if (!can_go && dir != DIR_LEFT) dir <= dir_e'(dir + 2'd1);
        S_ADVANCE: begin
          visited[vidx(nb_y, nb_x)] <= 1'b1;
          path[cor_r][cor_c]        <= 1'b1;
          path[sq(nb_y)][sq(nb_x)]  <= 1'b1;
          path_len <= path_len + LW'(1);
        end
        S_BACKTRACK: begin
          path[sq(cur_y)][sq(cur_x)] <= 1'b0;
          if (!one) path[par_r][par_c] <= 1'b0;
          path_len <= path_len - LW'(1);
        end
        S_FOUND: begin
          path[size-1][sq(exit_x)] <= 1'b1;
          done  <= 1'b1;
          found <= 1'b1;
          busy  <= 1'b0;
        end
        S_FAIL: begin
          path     <= '0;
          path_len <= '0;
          done     <= 1'b1;
          found    <= 1'b0;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_solver.sv
// tb_maze_solver: directed scenarios for maze_solver with
// hand-derived cycle counts and path bitmaps.
module tb_maze_solver;

  logic             clk;
  logic             rst;
  logic             start;
  logic [8:0][8:0]  maze;
  logic             busy;
  logic             done;
  logic             found;
  logic [8:0][8:0]  path;
  logic [4:0]       path_len;

  int cmp;
  int bad;

  maze_solver dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .maze     (maze),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .path     (path),
    .path_len (path_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0][8:0] straight_maze();
    logic [8:0][8:0] m;
    m = '1;
    for (int r = 0; r < 9; r++) m[r][1] = 1'b0;
    return m;
  endfunction

  function automatic logic [8:0][8:0] straight_path();
    logic [8:0][8:0] p;
    p = '0;
    for (int r = 0; r < 9; r++) p[r][1] = 1'b1;
    return p;
  endfunction

  // Leaves the bench at the negedge right after the accept edge.
  task automatic do_start(input logic [8:0][8:0] m);
    @(negedge clk);
    maze  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    maze  = '1;
    repeat (3) @(negedge clk);
    cmp++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    cmp++; if (done !== 1'b0) begin bad++;
      $display("FAIL reset_done: got %b want 0", done); end
    cmp++; if (found !== 1'b0) begin bad++;
      $display("FAIL reset_found: got %b want 0", found); end
    cmp++; if (path !== '0) begin bad++;
      $display("FAIL reset_path: got %h want 0", path); end
    cmp++; if (path_len !== 5'd0) begin bad++;
      $display("FAIL reset_len: got %0d want 0", path_len); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_straight();
    int cyc;
    do_start(straight_maze());
    cmp++; if (busy !== 1'b1 || done !== 1'b0) begin bad++;
      $display("FAIL straight_accept: got busy=%b done=%b want 1/0",
               busy, done); end
    wait_done(200, cyc);
    cmp++; if (cyc !== 14) begin bad++;
      $display("FAIL straight_cycles: got %0d want 14", cyc); end
    cmp++; if (found !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL straight_flags: got found=%b busy=%b want 1/0",
               found, busy); end
    cmp++; if (path_len !== 5'd4) begin bad++;
      $display("FAIL straight_len: got %0d want 4", path_len); end
    cmp++; if (path !== straight_path()) begin bad++;
      $display("FAIL straight_path: got %h want %h",
               path, straight_path()); end
  endtask

  task automatic test_dead_end();
    int cyc;
    logic [8:0][8:0] m;
    logic [8:0][8:0] e;
    m = '1;
    m[0][1] = 0; m[1][1] = 0; m[2][1] = 0; m[3][1] = 0;
    m[1][2] = 0; m[1][3] = 0;
    for (int r = 2; r < 9; r++) m[r][3] = 1'b0;
    e = '0;
    e[0][1] = 1; e[1][1] = 1; e[1][2] = 1;
    for (int r = 1; r < 9; r++) e[r][3] = 1'b1;
    do_start(m);
    cmp++; if (busy !== 1'b1 || done !== 1'b0) begin bad++;
      $display("FAIL dead_accept: got busy=%b done=%b want 1/0",
               busy, done); end
    wait_done(300, cyc);
    cmp++; if (done !== 1'b1 || found !== 1'b1) begin bad++;
      $display("FAIL dead_found: got done=%b found=%b want 1/1",
               done, found); end
    cmp++; if (path_len !== 5'd5) begin bad++;
      $display("FAIL dead_len: got %0d want 5", path_len); end
    cmp++; if (path !== e) begin bad++;
      $display("FAIL dead_path: got %h want %h", path, e); end
  endtask

  task automatic test_no_entry();
    int cyc;
    do_start('1);
    wait_done(100, cyc);
    cmp++; if (cyc !== 5) begin bad++;
      $display("FAIL noentry_cycles: got %0d want 5", cyc); end
    cmp++; if (found !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL noentry_flags: got found=%b busy=%b want 0/0",
               found, busy); end
    cmp++; if (path !== '0 || path_len !== 5'd0) begin bad++;
      $display("FAIL noentry_path: got %h len %0d want 0",
               path, path_len); end
  endtask

  task automatic test_unreachable();
    int cyc;
    logic [8:0][8:0] m;
    m = straight_maze();
    m[6][1] = 1'b1;
    do_start(m);
    wait_done(300, cyc);
    cmp++; if (cyc !== 28) begin bad++;
      $display("FAIL unreach_cycles: got %0d want 28", cyc); end
    cmp++; if (done !== 1'b1 || found !== 1'b0) begin bad++;
      $display("FAIL unreach_flags: got done=%b found=%b want 1/0",
               done, found); end
    cmp++; if (path !== '0 || path_len !== 5'd0) begin bad++;
      $display("FAIL unreach_path: got %h len %0d want 0",
               path, path_len); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_start(straight_maze());
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp++; if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0)
      begin bad++;
      $display("FAIL midrst_flags: got %b%b%b want 000",
               busy, done, found); end
    cmp++; if (path !== '0 || path_len !== 5'd0) begin bad++;
      $display("FAIL midrst_path: got %h len %0d want 0",
               path, path_len); end
    rst = 1'b0;
    do_start(straight_maze());
    wait_done(200, cyc);
    cmp++; if (cyc !== 14 || found !== 1'b1) begin bad++;
      $display("FAIL midrst_resolve: got cyc=%0d found=%b want 14/1",
               cyc, found); end
    cmp++; if (path !== straight_path() || path_len !== 5'd4)
      begin bad++;
      $display("FAIL midrst_path2: got %h len %0d want %h len 4",
               path, path_len, straight_path()); end
  endtask

  task automatic test_start_busy();
    int cyc;
    do_start(straight_maze());
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        maze  = '1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    cmp++; if (cyc !== 14) begin bad++;
      $display("FAIL busy_cycles: got %0d want 14", cyc); end
    cmp++; if (found !== 1'b1 || path_len !== 5'd4) begin bad++;
      $display("FAIL busy_result: got found=%b len %0d want 1/4",
               found, path_len); end
    cmp++; if (path !== straight_path()) begin bad++;
      $display("FAIL busy_path: got %h want %h",
               path, straight_path()); end
    cmp++; if (done === 1'b1 && busy === 1'b1) begin bad++;
      $display("FAIL busy_done_both: got 11 want not both"); end
  endtask

  initial begin
    cmp = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    maze = '1;
    test_reset();
    test_straight();
    test_dead_end();
    test_no_entry();
    test_unreachable();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
